// File: rtl/lc3b_fetch_unit.sv
// LC-3b instruction-fetch stage: owns the PC, runs the imem read handshake and feeds IF/ID.
// Optional perf counters are built only when LC3B_FETCH_PERF_EN is defined.
module lc3b_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        imem_read,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        imem_resp,
   output logic [31:0] ifid_bundle,
   output logic        ifid_load,
   output logic        ifid_flush
`ifdef LC3B_FETCH_PERF_EN
   ,
   output logic [15:0] perf_fetched,
   output logic [15:0] perf_stalls
`endif
);

   typedef enum logic [1:0] {REQ, HOLD, DISCARD} state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] hold_buf_q, hold_buf_d;
   logic [15:0] disc_addr_q, disc_addr_d;

   logic [15:0] pc_inc, target;
   logic        read_c, load_c;
   logic [15:0] addr_c, data_c;

   assign pc_inc = pc_q + 16'd2;
   assign target = {redirect_pc[15:1], 1'b0};

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      hold_buf_d  = hold_buf_q;
      disc_addr_d = disc_addr_q;
      read_c      = 1'b0;
      load_c      = 1'b0;
      addr_c      = pc_q;
      data_c      = imem_rdata;
      case (state_q)
         REQ: begin
            read_c = 1'b1;
            if (redirect) begin
               pc_d = target;
               // The read already on the bus must complete before a new address can go out
               if (!imem_resp) begin
                  disc_addr_d = pc_q;
                  state_d     = DISCARD;
               end
            end else if (imem_resp) begin
               if (stall) begin
                  hold_buf_d = imem_rdata;
                  state_d    = HOLD;
               end else begin
                  load_c = 1'b1;
                  pc_d   = pc_inc;
               end
            end
         end
         HOLD: begin
            data_c = hold_buf_q;
            if (redirect) begin
               pc_d    = target;
               state_d = REQ;
            end else if (!stall) begin
               load_c  = 1'b1;
               pc_d    = pc_inc;
               state_d = REQ;
            end
         end
         DISCARD: begin
            read_c = 1'b1;
            addr_c = disc_addr_q;
            if (redirect) pc_d = target;
            if (imem_resp) state_d = REQ;
         end
         default: state_d = REQ;
      endcase
      if (!reset) begin
         state_d     = REQ;
         pc_d        = RESET_PC;
         hold_buf_d  = 16'h0000;
         disc_addr_d = 16'h0000;
      end
   end

   always_ff @(posedge clk) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_buf_q  <= hold_buf_d;
      disc_addr_q <= disc_addr_d;
   end

   // Redirect squashes any delivery in the same cycle; reset gates every output
   assign imem_read   = reset & read_c;
   assign imem_addr   = reset ? addr_c : 16'h0000;
   assign ifid_load   = reset & load_c & ~redirect;
   assign ifid_flush  = reset & redirect;
   assign ifid_bundle = reset ? {pc_inc, data_c} : 32'h0;

`ifdef LC3B_FETCH_PERF_EN
   logic [15:0] perf_fetched_q, perf_fetched_d;
   logic [15:0] perf_stalls_q, perf_stalls_d;

   always_comb begin
      perf_fetched_d = perf_fetched_q;
      perf_stalls_d  = perf_stalls_q;
      if (ifid_load && perf_fetched_q != 16'hFFFF)
         perf_fetched_d = perf_fetched_q + 16'd1;
      if (stall && state_q != DISCARD && perf_stalls_q != 16'hFFFF)
         perf_stalls_d = perf_stalls_q + 16'd1;
      if (!reset) begin
         perf_fetched_d = 16'h0000;
         perf_stalls_d  = 16'h0000;
      end
   end

   always_ff @(posedge clk) begin
      perf_fetched_q <= perf_fetched_d;
      perf_stalls_q  <= perf_stalls_d;
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stalls  = perf_stalls_q;
`endif

endmodule
